// File: rtl/bitwise_reducer_pkg.sv
// Shared op codes and FSM state type for the bitwise reducer and its
// combinational op unit.
package bitwise_reducer_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_reducer_op_unit.sv
// Combinational two-word OR/AND/XOR selected by op; NOR is not handled here,
// callers map it to OR and invert downstream.
module bitwise_op_unit
  import bitwise_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a | b;
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/bitwise_reducer.sv
// Folds a handshaked stream of len+1 words into one word using OR/AND/XOR/NOR,
// presenting the result on a valid/ready output port.
module bitwise_reducer
  import bitwise_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  op_e              op_q;
  op_e              unit_op;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] out_q;
  logic             accept;
  logic             last;

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;

  assign accept = in_valid && in_ready;
  // Compare precedes the increment, so cnt wrapping at N=2^LEN_W is harmless.
  assign last   = accept && (cnt_q == len_q);

  // NOR accumulates as OR; the inversion happens when the result is registered.
  assign unit_op = (op_q == OP_NOR) ? OP_OR : op_q;

  bitwise_op_unit #(
    .WIDTH (WIDTH)
  ) u_op (
    .op (unit_op),
    .a  (acc_q),
    .b  (in_data),
    .y  (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_ACCUM;
      S_ACCUM: if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= OP_OR;
      len_q <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_e'(op);
            len_q <= len;
            cnt_q <= '0;
            acc_q <= (op_e'(op) == OP_AND) ? '1 : '0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + LEN_W'(1);
            if (last) begin
              out_q <= (op_q == OP_NOR) ? ~acc_nxt : acc_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_reducer.sv
// Scoreboard bench for bitwise_reducer: stimulus pushes expected results, a
// monitor pops and compares each result the DUT hands over.
module tb_bitwise_reducer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [WIDTH-1:0] sb[$];

  bitwise_reducer #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handed-over result is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got=%h expected=none", out_data);
      end else begin
        check("out_data", {16'h0, out_data}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] o, input logic [LEN_W-1:0] l);
    start = 1'b1;
    op    = o;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("send_accepted", {31'h0, done}, 32'h1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
      else step();
    end
    check("wait_idle", {31'h0, idle}, 32'h1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] held;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // OR back-to-back, out_valid one cycle after the last accept
    sb.push_back(16'h8F01);
    do_start(2'd0, 4'd2);
    send(16'h0001); send(16'h0F00); send(16'h8000);
    @(negedge clk);
    check("or_out_valid", {31'h0, out_valid}, 32'h1);
    step();
    @(negedge clk);
    check("or_idle_after", {31'h0, busy}, 32'h0);
    step();

    // AND with two bubble cycles
    sb.push_back(16'h0FF0);
    do_start(2'd1, 4'd1);
    send(16'hFFF0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("and_bubble_ready", {31'h0, in_ready}, 32'h1);
      check("and_bubble_nodone", {31'h0, out_valid}, 32'h0);
      step();
    end
    send(16'h0FFF);
    wait_idle();

    // single-operand XOR and NOR
    sb.push_back(16'hA5A5);
    do_start(2'd2, 4'd0);
    send(16'hA5A5);
    wait_idle();
    sb.push_back(16'hFF00);
    do_start(2'd3, 4'd0);
    send(16'h00FF);
    wait_idle();

    // backpressure with an ignored start during DONE
    out_ready = 1'b0;
    sb.push_back(16'h1234);
    do_start(2'd0, 4'd0);
    send(16'h1234);
    @(negedge clk);
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    held = out_data;
    check("bp_data", {16'h0, held}, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) begin start = 1'b1; op = 2'd1; len = 4'd3; end
      if (i == 2) start = 1'b0;
      @(negedge clk);
      check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
      check("bp_hold_data", {16'h0, out_data}, {16'h0, held});
    end
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_idle_busy", {31'h0, busy}, 32'h0);
    check("bp_idle_ready", {31'h0, in_ready}, 32'h0);
    step();
    @(negedge clk);
    check("bp_start_ignored", {31'h0, busy}, 32'h0);
    step();

    // reset mid-ACCUM discards the partial result
    do_start(2'd0, 4'd3);
    send(16'h0011); send(16'h0022);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_in_ready", {31'h0, in_ready}, 32'h0);
    check("abort_out_valid", {31'h0, out_valid}, 32'h0);
    check("abort_out_data", {16'h0, out_data}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    sb.push_back(16'h1234);
    do_start(2'd0, 4'd0);
    send(16'h1234);
    wait_idle();

    // maximum length: 16 XOR operands 0..15 fold to zero
    sb.push_back(16'h0000);
    do_start(2'd2, 4'd15);
    for (int i = 0; i < 16; i++) send(WIDTH'(i));
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    @(negedge clk);
    check("max_extra_ready", {31'h0, in_ready}, 32'h0);
    check("max_valid", {31'h0, out_valid}, 32'h1);
    step();
    @(negedge clk);
    check("max_idle_ready", {31'h0, in_ready}, 32'h0);
    check("max_idle_busy", {31'h0, busy}, 32'h0);
    step();
    in_valid = 1'b0;

    step(); step();
    check("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
